multicycle_rv32i_core: RTL and testbench
========================================

Name: multicycle_rv32i_core

Overview:
- Multicycle RV32I-subset processor core; same external pin-out as `top_proc`.
- Fetches from an external synchronous instruction ROM (`INSTRUCTION_MEMORY`) and accesses an external synchronous data RAM (`DATA_MEMORY`); both memories live outside this block.
- Each instruction takes exactly five cycles through a fixed IF→ID→EX→MEM→WB state machine.

Parameters:
- INITIAL_PC, 32'h0040_0000, PC value loaded on reset. Memories decode only PC[8:0].

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- instr  input  32  instruction word from ROM. Synchronous read: valid one cycle after PC changes.
- dReadData  input  32  RAM read data. Synchronous read: valid the cycle after the address is presented.
- PC  output  32  current program counter (byte address).
- dAddress  output  32  data address; equals the ALU result.
- dWriteData  output  32  store data; equals register rs2.
- MemRead  output  1  high in MEM for LW.
- MemWrite  output  1  high in MEM for SW; RAM writes on that edge.
- WriteBackData  output  32  register write value: dReadData for LW, ALU result otherwise.

Behaviour:
- Reset (async, any state): PC=INITIAL_PC, state=IF, all 32 registers cleared, MemRead=MemWrite=0. Datapath outputs are combinational from cleared state.
- FSM: IF→ID→EX→MEM→WB→IF, unconditional, one cycle each. Every instruction spends a full slot in every state. PC changes only at the WB→IF edge, so each instruction takes 5 cycles.
- Instruction register: captures `instr` at the ID→EX edge. Register file read in ID, operands latched for EX.
- Supported instructions:
  - R-type (opcode 0110011): ADD, SUB, AND, OR, XOR, SLT, SLL, SRL, SRA.
  - I-ALU (0010011): ADDI, ANDI, ORI, XORI, SLTI, SLLI, SRLI, SRAI.
  - LW (0000011), SW (0100011), BEQ (1100011).
- Unknown opcodes: treated as NOP (PC+4, no write).
- Immediates: I-type imm[11:0], S-type {[31:25],[11:7]}, B-type {[31],[7],[30:25],[11:8],0}. All sign-extended to 32 bits.
- ALU: 32-bit, wrap-around add/sub.
  - SLT is signed and yields 1 or 0.
  - Shift amount is operand B[4:0]; SRA is arithmetic.
  - Zero flag = (result==0).
- ALU op encoding (4 bits): AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, SRL 1000, SLL 1001, SRA 1010, XOR 1101.
  - LW/SW use ADD; BEQ uses SUB.
  - For R-type, funct7[5] selects SUB/SRA; for I-type it only selects SRAI.
- MEM state: dAddress = ALU result (latched in EX). MemRead=1 for LW; MemWrite=1 for SW (one cycle only).
- WB state:
  - Register write for R/I/LW when rd≠0. Writes to x0 are ignored; x0 always reads 0.
  - Next PC = PC + B-imm if BEQ and Zero, else PC+4. Loaded at WB→IF edge.
- Reset asserted mid-instruction: instruction aborted, no partial write completes after reset.

Decomposition:
- Shared package: opcode constants, ALU op constants, FSM state enum (IF, ID, EX, MEM, WB), INITIAL_PC default.
- Sub-modules: `alu` (combinational) and `regfile` (32x32, two read ports, one write port, async reset).
- Top level holds FSM, PC register, immediate generator, operand/result latches, next-PC logic.

Test Plan:
- Reset: rst=1 for 10 ns → PC=0x0040_0000, MemRead=MemWrite=0. After release, PC=0x0040_0004 after 5 cycles, 0x0040_0008 after 10.
- ADDI x1,x0,5; ADDI x2,x0,-3; ADD x3,x1,x2 → WriteBackData in WB = 5, 0xFFFF_FFFD, 0x0000_0002 respectively.
- SW x3,8(x0) then LW x4,8(x0):
  - SW: MemWrite high exactly one cycle with dAddress=8, dWriteData=2.
  - LW: MemRead high in MEM, WriteBackData=2 in WB.
- BEQ x1,x1,+8 → PC advances by 8. BEQ x1,x2,+8 → PC advances by 4. No register write in either case.
- SRAI x5,x2,1 → 0xFFFF_FFFE. SRLI x6,x2,28 → 0xF. SLT x7,x2,x1 → 1. SUB x8,x1,x1 → 0.
- ADDI x0,x0,7 then ADD x9,x0,x0 → x9 = 0. Separately, assert rst during MEM of an SW → no RAM write, PC returns to 0x0040_0000.

Source files
------------

// File: rtl/multicycle_rv32i_core_pkg.sv
// Shared constants, ALU/FSM enums and the ALU-control decoder for the multicycle RV32I core.
package multicycle_rv32i_core_pkg;

  localparam logic [31:0] INITIAL_PC_DEF = 32'h0040_0000;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000, ALU_OR  = 4'b0001, ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0110, ALU_SLT = 4'b0111, ALU_SRL = 4'b1000,
    ALU_SLL = 4'b1001, ALU_SRA = 4'b1010, ALU_XOR = 4'b1101
  } alu_op_e;

  typedef enum logic [2:0] {S_IF, S_ID, S_EX, S_MEM, S_WB} state_e;

  // funct7[5] picks SUB only for R-type; for immediates it only distinguishes SRAI.
  function automatic alu_op_e alu_dec(input logic [6:0] opcode, input logic [2:0] funct3,
                                      input logic f7b5);
    alu_op_e op;
    op = ALU_ADD;
    if (opcode == OP_R || opcode == OP_I) begin
      case (funct3)
        3'b000:  op = (opcode == OP_R && f7b5) ? ALU_SUB : ALU_ADD;
        3'b001:  op = ALU_SLL;
        3'b010:  op = ALU_SLT;
        3'b100:  op = ALU_XOR;
        3'b101:  op = f7b5 ? ALU_SRA : ALU_SRL;
        3'b110:  op = ALU_OR;
        3'b111:  op = ALU_AND;
        default: op = ALU_ADD;
      endcase
    end else if (opcode == OP_BEQ) begin
      op = ALU_SUB;
    end
    return op;
  endfunction

endpackage

// File: rtl/multicycle_rv32i_core_if.sv
// Instruction-ROM / data-RAM bus of the core; master is the core, slave the memories.
interface multicycle_rv32i_core_if;
  logic [31:0] instr;
  logic [31:0] dReadData;
  logic [31:0] PC;
  logic [31:0] dAddress;
  logic [31:0] dWriteData;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] WriteBackData;

  modport master (input instr, dReadData,
                  output PC, dAddress, dWriteData, MemRead, MemWrite, WriteBackData);
  modport slave  (output instr, dReadData,
                  input PC, dAddress, dWriteData, MemRead, MemWrite, WriteBackData);
endinterface

// File: rtl/multicycle_rv32i_core_alu.sv
// Combinational 32-bit ALU with zero flag.
module multicycle_rv32i_core_alu
  import multicycle_rv32i_core_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  alu_op_e     op,
  output logic [31:0] y,
  output logic        zero
);

  always_comb begin
    y = '0;
    case (op)
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_SLT: y = {31'b0, $signed(a) < $signed(b)};
      ALU_SRL: y = a >> b[4:0];
      ALU_SLL: y = a << b[4:0];
      ALU_SRA: y = $signed(a) >>> b[4:0];
      ALU_XOR: y = a ^ b;
      default: y = '0;
    endcase
  end

  assign zero = (y == '0);

endmodule

// File: rtl/multicycle_rv32i_core_regfile.sv
// 32x32 register file, two async read ports, one write port; x0 hardwired to zero.
module multicycle_rv32i_core_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd
);

  logic [31:0][31:0] regs;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   regs     <= '0;
    else if (we && wa != 5'd0) regs[wa] <= wd;
  end

  assign rd1 = (ra1 == 5'd0) ? '0 : regs[ra1];
  assign rd2 = (ra2 == 5'd0) ? '0 : regs[ra2];

endmodule

// File: rtl/multicycle_rv32i_core.sv
// Multicycle RV32I-subset core: fixed IF/ID/EX/MEM/WB sequence, five cycles per instruction.
module multicycle_rv32i_core
  import multicycle_rv32i_core_pkg::*;
#(
  parameter logic [31:0] INITIAL_PC = INITIAL_PC_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  multicycle_rv32i_core_if.master      bus
);

  state_e      state, state_nxt;
  logic [31:0] pc, ir, a_q, b_q, alu_q;
  logic        zero_q;
  logic [31:0] rd1, rd2, imm_i, imm_s, imm_b, alu_b, alu_y, pc_nxt;
  logic        alu_zero, mem_read, mem_write, rf_we;
  logic [6:0]  opcode;
  alu_op_e     alu_op;
  logic        unused_rs1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IF;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    rf_we     = 1'b0;
    case (state)
      S_IF:    state_nxt = S_ID;
      S_ID:    state_nxt = S_EX;
      S_EX:    state_nxt = S_MEM;
      S_MEM: begin
        state_nxt = S_WB;
        mem_read  = (opcode == OP_LW);
        mem_write = (opcode == OP_SW);
      end
      S_WB: begin
        state_nxt = S_IF;
        rf_we     = (opcode == OP_R) || (opcode == OP_I) || (opcode == OP_LW);
      end
      default: state_nxt = S_IF;
    endcase
  end

  assign opcode     = ir[6:0];
  assign unused_rs1 = ^ir[19:15];
  assign imm_i      = {{20{ir[31]}}, ir[31:20]};
  assign imm_s      = {{20{ir[31]}}, ir[31:25], ir[11:7]};
  assign imm_b      = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
  assign alu_op     = alu_dec(opcode, ir[14:12], ir[30]);
  assign alu_b      = (opcode == OP_I || opcode == OP_LW) ? imm_i :
                      (opcode == OP_SW)                   ? imm_s : b_q;
  assign pc_nxt     = (opcode == OP_BEQ && zero_q) ? pc + imm_b : pc + 32'd4;

  // instr is only valid in ID, so the register file is addressed straight from the ROM word.
  multicycle_rv32i_core_regfile u_rf (
    .clk (clk), .rst (rst),
    .ra1 (bus.instr[19:15]), .ra2 (bus.instr[24:20]),
    .rd1 (rd1), .rd2 (rd2),
    .we  (rf_we), .wa (ir[11:7]), .wd (bus.WriteBackData)
  );

  multicycle_rv32i_core_alu u_alu (
    .a (a_q), .b (alu_b), .op (alu_op), .y (alu_y), .zero (alu_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc     <= INITIAL_PC;
      ir     <= '0;
      a_q    <= '0;
      b_q    <= '0;
      alu_q  <= '0;
      zero_q <= 1'b0;
    end else begin
      if (state == S_ID) begin
        ir  <= bus.instr;
        a_q <= rd1;
        b_q <= rd2;
      end
      if (state == S_EX) begin
        alu_q  <= alu_y;
        zero_q <= alu_zero;
      end
      if (state == S_WB) pc <= pc_nxt;
    end
  end

  assign bus.PC            = pc;
  assign bus.dAddress      = alu_q;
  assign bus.dWriteData    = b_q;
  assign bus.MemRead       = mem_read;
  assign bus.MemWrite      = mem_write;
  assign bus.WriteBackData = (opcode == OP_LW) ? bus.dReadData : alu_q;

endmodule

// File: tb/tb_multicycle_rv32i_core.sv
// Directed bench: small program in a model ROM/RAM, hand-computed WB data, strobes and next PC.
module tb_multicycle_rv32i_core;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_pass = 0;

  logic [31:0] rom [0:127];
  logic [31:0] ram [0:127];

  multicycle_rv32i_core_if bus ();

  multicycle_rv32i_core dut (.clk (clk), .rst (rst), .bus (bus));

  always #5 clk = ~clk;

  always @(posedge clk) bus.instr <= rom[bus.PC[8:2]];

  always @(posedge clk) begin
    if (bus.MemWrite) ram[bus.dAddress[8:2]] <= bus.dWriteData;
    bus.dReadData <= ram[bus.dAddress[8:2]];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Walks one instruction from IF through the next IF, checking strobes, WB data and next PC.
  task automatic run_instr(input string tag, input bit chk_wb, input logic [31:0] exp_wb,
                           input bit exp_rd, input bit exp_wr, input logic [31:0] exp_addr,
                           input logic [31:0] exp_wdata, input logic [31:0] exp_pc);
    tick;  // ID
    tick;  // EX
    chk({tag, "_ex_memwrite"}, {31'b0, bus.MemWrite}, 32'd0);
    tick;  // MEM
    chk({tag, "_memread"}, {31'b0, bus.MemRead}, {31'b0, exp_rd});
    chk({tag, "_memwrite"}, {31'b0, bus.MemWrite}, {31'b0, exp_wr});
    if (exp_rd || exp_wr) chk({tag, "_daddr"}, bus.dAddress, exp_addr);
    if (exp_wr) chk({tag, "_wdata"}, bus.dWriteData, exp_wdata);
    tick;  // WB
    chk({tag, "_wb_memwrite"}, {31'b0, bus.MemWrite}, 32'd0);
    if (chk_wb) chk({tag, "_wbdata"}, bus.WriteBackData, exp_wb);
    tick;  // next IF
    chk({tag, "_pc"}, bus.PC, exp_pc);
  endtask

  initial begin
    for (int i = 0; i < 128; i++) begin
      rom[i] = 32'h0;
      ram[i] = 32'h0;
    end
    rom[0]  = 32'h00500093;  // ADDI x1,x0,5
    rom[1]  = 32'hFFD00113;  // ADDI x2,x0,-3
    rom[2]  = 32'h002081B3;  // ADD  x3,x1,x2
    rom[3]  = 32'h00302423;  // SW   x3,8(x0)
    rom[4]  = 32'h00802203;  // LW   x4,8(x0)
    rom[5]  = 32'h00108463;  // BEQ  x1,x1,+8
    rom[6]  = 32'h00100513;  // ADDI x10,x0,1 (skipped)
    rom[7]  = 32'h00208463;  // BEQ  x1,x2,+8
    rom[8]  = 32'h40115293;  // SRAI x5,x2,1
    rom[9]  = 32'h01C15313;  // SRLI x6,x2,28
    rom[10] = 32'h001123B3;  // SLT  x7,x2,x1
    rom[11] = 32'h40108433;  // SUB  x8,x1,x1
    rom[12] = 32'h00700013;  // ADDI x0,x0,7
    rom[13] = 32'h000004B3;  // ADD  x9,x0,x0
    rom[14] = 32'h00102623;  // SW   x1,12(x0)

    #9;
    chk("rst_pc", bus.PC, 32'h0040_0000);
    chk("rst_memread", {31'b0, bus.MemRead}, 32'd0);
    chk("rst_memwrite", {31'b0, bus.MemWrite}, 32'd0);
    #1 rst = 1'b0;

    run_instr("addi_x1", 1'b1, 32'h0000_0005, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0040_0004);
    run_instr("addi_x2", 1'b1, 32'hFFFF_FFFD, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0040_0008);
    run_instr("add_x3",  1'b1, 32'h0000_0002, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0040_000C);
    run_instr("sw_x3",   1'b0, 32'h0,         1'b0, 1'b1, 32'h8, 32'h2, 32'h0040_0010);
    chk("ram_word2", ram[2], 32'h0000_0002);
    run_instr("lw_x4",   1'b1, 32'h0000_0002, 1'b1, 1'b0, 32'h8, 32'h0, 32'h0040_0014);
    run_instr("beq_tk",  1'b0, 32'h0,         1'b0, 1'b0, 32'h0, 32'h0, 32'h0040_001C);
    run_instr("beq_nt",  1'b0, 32'h0,         1'b0, 1'b0, 32'h0, 32'h0, 32'h0040_0020);
    run_instr("srai_x5", 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0040_0024);
    run_instr("srli_x6", 1'b1, 32'h0000_000F, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0040_0028);
    run_instr("slt_x7",  1'b1, 32'h0000_0001, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0040_002C);
    run_instr("sub_x8",  1'b1, 32'h0000_0000, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0040_0030);
    run_instr("addi_x0", 1'b1, 32'h0000_0007, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0040_0034);
    run_instr("add_x9",  1'b1, 32'h0000_0000, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0040_0038);

    // SW x1,12(x0) interrupted by reset while in MEM.
    tick;  // ID
    tick;  // EX
    tick;  // MEM
    chk("sw12_memwrite", {31'b0, bus.MemWrite}, 32'd1);
    rst = 1'b1;
    #1;
    chk("midrst_pc", bus.PC, 32'h0040_0000);
    chk("midrst_memwrite", {31'b0, bus.MemWrite}, 32'd0);
    tick;
    chk("midrst_ram_word3", ram[3], 32'h0000_0000);
    #2 rst = 1'b0;

    run_instr("rerun_addi", 1'b1, 32'h0000_0005, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0040_0004);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
